// File: rtl/fifo_wframe_if.sv
// Upstream frame stream into the dual-clock FIFO writer.
interface fifo_wframe_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned LENW  = 5
) ();
  logic             s_valid;
  logic             s_ready;
  logic [DSIZE-1:0] s_data;
  logic [LENW-1:0]  s_len;
  logic             s_last;

  // Source of frames
  modport master (
    output s_valid,
    output s_data,
    output s_len,
    output s_last,
    input  s_ready
  );

  // Frame writer
  modport slave (
    input  s_valid,
    input  s_data,
    input  s_len,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/fifo_wframe_writer.sv
// Write-domain frame producer: admits a whole frame only when the FIFO has room for it,
// discards malformed frames and keeps frame/drop statistics.
module fifo_wframe_writer #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned LENW     = 5
) (
  input  logic                wclk,
  input  logic                wrst_n,
  fifo_wframe_if.slave        s_if,
  input  logic                i_wfull,
  input  logic [ADDRSIZE:0]   i_wptr,
  input  logic [ADDRSIZE:0]   i_wq2_rptr,
  output logic                o_winc,
  output logic [DSIZE-1:0]    o_wdata,
  output logic [ADDRSIZE:0]   o_free,
  output logic [15:0]         o_frame_cnt,
  output logic [15:0]         o_drop_cnt,
  output logic                o_len_err
);

  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
  // Common width for comparing frame lengths with free-space counts
  localparam int unsigned CW = (LENW > ADDRSIZE + 1) ? LENW : ADDRSIZE + 1;

  typedef enum logic [1:0] {StIdle, StCheck, StWrite, StDrop} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [LENW-1:0]    r_len;
  logic [LENW-1:0]    w_len_d;
  logic [LENW-1:0]    r_beat;
  logic [LENW-1:0]    w_beat_d;
  logic               r_winc;
  logic               w_winc_d;
  logic [DSIZE-1:0]   r_wdata;
  logic [DSIZE-1:0]   w_wdata_d;
  logic [ADDRSIZE:0]  r_free;
  logic [15:0]        r_frame_cnt;
  logic [15:0]        r_drop_cnt;
  logic               r_len_err;
  logic               w_len_err_d;
  logic               w_frame_inc;
  logic               w_drop_inc;
  logic               w_ready;
  logic               w_hs;
  logic               w_last_beat;
  logic               w_len_bad;

  logic [ADDRSIZE:0]  w_wbin;
  logic [ADDRSIZE:0]  w_rbin;
  logic [ADDRSIZE:0]  w_used;
  logic [ADDRSIZE:0]  w_free_d;
  logic [CW-1:0]      w_free_ext;
  logic [CW-1:0]      w_rlen_ext;
  logic [CW-1:0]      w_slen_ext;
  logic [CW-1:0]      w_depth_ext;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = int'(ADDRSIZE) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Free space: modulo subtraction handles pointer wrap; an in-flight write is never free
  always_comb begin
    w_wbin   = gray2bin(i_wptr);
    w_rbin   = gray2bin(i_wq2_rptr);
    w_used   = w_wbin - w_rbin;
    w_free_d = DEPTH - w_used - {{ADDRSIZE{1'b0}}, r_winc};
  end

  assign w_free_ext  = CW'(r_free);
  assign w_rlen_ext  = CW'(r_len);
  assign w_slen_ext  = CW'(s_if.s_len);
  assign w_depth_ext = CW'(DEPTH);
  assign w_len_bad   = (s_if.s_len == '0) || (w_slen_ext > w_depth_ext);
  assign w_last_beat = (r_beat == r_len - LENW'(1));
  assign w_hs        = s_if.s_valid & w_ready;

  // Frame admission FSM: next state, handshake and per-beat actions
  always_comb begin
    w_state_d   = r_state;
    w_ready     = 1'b0;
    w_len_d     = r_len;
    w_beat_d    = r_beat;
    w_winc_d    = 1'b0;
    w_wdata_d   = r_wdata;
    w_frame_inc = 1'b0;
    w_drop_inc  = 1'b0;
    w_len_err_d = 1'b0;
    case (r_state)
      StIdle: begin
        w_beat_d = '0;
        if (s_if.s_valid) begin
          w_len_d = s_if.s_len;
          if (w_len_bad) begin
            w_state_d  = StDrop;
            w_drop_inc = 1'b1;
          end else begin
            w_state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (w_free_ext >= w_rlen_ext) begin
          w_state_d = StWrite;
        end
      end
      StWrite: begin
        // wfull only guards against broken space accounting
        w_ready = ~i_wfull;
        if (w_hs) begin
          w_winc_d  = 1'b1;
          w_wdata_d = s_if.s_data;
          w_beat_d  = r_beat + LENW'(1);
          if (s_if.s_last) begin
            w_state_d = StIdle;
            if (w_last_beat) begin
              w_frame_inc = 1'b1;
            end else begin
              w_len_err_d = 1'b1;
              w_drop_inc  = 1'b1;
            end
          end else if (w_last_beat) begin
            w_state_d   = StDrop;
            w_len_err_d = 1'b1;
            w_drop_inc  = 1'b1;
          end
        end
      end
      StDrop: begin
        w_ready = 1'b1;
        if (w_hs && s_if.s_last) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State, write port, free count and statistics registers
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_beat      <= '0;
      r_winc      <= 1'b0;
      r_wdata     <= '0;
      r_free      <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_len     <= w_len_d;
      r_beat    <= w_beat_d;
      r_winc    <= w_winc_d;
      r_wdata   <= w_wdata_d;
      r_free    <= w_free_d;
      r_len_err <= w_len_err_d;
      if (w_frame_inc && (r_frame_cnt != 16'hFFFF)) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign s_if.s_ready = w_ready;
  assign o_winc       = r_winc;
  assign o_wdata      = r_wdata;
  assign o_free       = r_free;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_len_err    = r_len_err;

endmodule
